// File: rtl/ttr_pkg.sv
// Shared types and constants for the truth-table reader.
package ttr_pkg;

  localparam int NUM_VECTORS = 16;
  localparam int IDX_W       = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Double-register the async input; both flops clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/truth_table_reader.sv
// Sweeps all 16 input vectors of a 4-input circuit, samples its output
// after a settle delay and captures the resulting hex truth-table code.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | drivers at 0, waiting for start
// ST_SETTLE  | vector idx applied, settle down-counter running
// ST_SAMPLE  | store synchronized output into accumulator bit idx
// ST_DONE    | publish table/match, pulse done on the way back to IDLE
module truth_table_reader
  import ttr_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  input  logic        dut_out,
  output logic        drv_in1,
  output logic        drv_in2,
  output logic        drv_in3,
  output logic        drv_in4,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic        match
);

  // Counter is loaded with SETTLE_CYCLES-1 so SETTLE lasts exactly
  // SETTLE_CYCLES cycles before terminal count moves to SAMPLE.
  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       r_drv;
  logic [7:0]             r_cnt;
  logic [NUM_VECTORS-1:0] r_acc;
  logic [NUM_VECTORS-1:0] r_table;
  logic                   r_match;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_sync;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (dut_out),
    .o_q   (w_sync)
  );

  // Sweep sequencer with registered outputs; abort overrides every
  // non-idle state and also blocks a simultaneous start in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_drv   <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_table <= '0;
      r_match <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort && (r_state != ST_IDLE)) begin
        r_state <= ST_IDLE;
        r_idx   <= '0;
        r_drv   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_drv <= '0;
            if (start && !abort) begin
              r_state <= ST_SETTLE;
              r_idx   <= '0;
              r_cnt   <= CNT_LOAD;
              r_acc   <= '0;
              r_busy  <= 1'b1;
            end
          end
          ST_SETTLE: begin
            if (r_cnt == 8'd0) begin
              r_state <= ST_SAMPLE;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          ST_SAMPLE: begin
            r_acc[r_idx] <= w_sync;
            if (r_idx == LAST_IDX) begin
              r_state <= ST_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_drv   <= r_idx + 1'b1;
              r_cnt   <= CNT_LOAD;
              r_state <= ST_SETTLE;
            end
          end
          ST_DONE: begin
            r_done  <= 1'b1;
            r_table <= r_acc;
            r_match <= (r_acc == expected);
            r_busy  <= 1'b0;
            r_idx   <= '0;
            r_drv   <= '0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_drv   <= '0;
          end
        endcase
      end
    end
  end

  assign drv_in1   = r_drv[3];
  assign drv_in2   = r_drv[2];
  assign drv_in3   = r_drv[1];
  assign drv_in4   = r_drv[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign table_out = r_table;
  assign match     = r_match;

endmodule

// File: tb/tb_truth_table_reader.sv
// Directed bench for truth_table_reader with a behavioural 4-input circuit.
module tb_truth_table_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] expected;
  logic        dut_out;
  logic        drv_in1, drv_in2, drv_in3, drv_in4;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic        match;

  int n_total = 0;
  int n_bad   = 0;

  // circuit model select: 0 = in1, 1 = in4, 2 = table 0xFC79
  int          ckt_mode = 0;
  logic [15:0] ckt_tab  = 16'hFC79;
  logic [3:0]  w_vec;

  truth_table_reader #(.SETTLE_CYCLES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .expected  (expected),
    .dut_out   (dut_out),
    .drv_in1   (drv_in1),
    .drv_in2   (drv_in2),
    .drv_in3   (drv_in3),
    .drv_in4   (drv_in4),
    .busy      (busy),
    .done      (done),
    .table_out (table_out),
    .match     (match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign w_vec = {drv_in1, drv_in2, drv_in3, drv_in4};
  always_comb begin
    dut_out = 1'b0;
    case (ckt_mode)
      0:       dut_out = drv_in1;
      1:       dut_out = drv_in4;
      default: dut_out = ckt_tab[w_vec];
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // Pulse start, wait for done, check latency and published results.
  task automatic run_sweep(input string tag, input logic [15:0] exp_tab, input logic exp_m);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'd81);
    check({tag, "_tab"}, 32'(table_out), 32'(exp_tab));
    check({tag, "_match"}, 32'(match), 32'(exp_m));
    check({tag, "_idle"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1 check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n_done;
    int t_first, t_second;
    logic saw_done;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; expected = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {table_out, 11'd0, match, busy, done, 2'd0}, 32'd0);
    check("rst_drv", 32'(w_vec), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // in1 tie -> FF00
    ckt_mode = 0; expected = 16'hFF00;
    run_sweep("in1", 16'hFF00, 1'b1);

    // in4 tie -> AAAA, mismatching reference
    ckt_mode = 1; expected = 16'h5555;
    run_sweep("in4", 16'hAAAA, 1'b0);

    // behavioural 0xFC79
    ckt_mode = 2; expected = 16'hFC79;
    run_sweep("fc79", 16'hFC79, 1'b1);

    // abort at cycle 30
    ckt_mode = 0; expected = 16'hFF00;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("abt_busy_pre", 32'(busy), 32'd1);
    check("abt_drv_pre", 32'(w_vec), 32'd6);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abt_busy", 32'(busy), 32'd0);
    check("abt_drv", 32'(w_vec), 32'd0);
    check("abt_tab", 32'(table_out), 32'hFC79);
    check("abt_match", 32'(match), 32'd1);
    saw_done = 1'b0;
    repeat (100) begin
      @(posedge clk);
      #1 if (done) saw_done = 1'b1;
    end
    check("abt_nodone", 32'(saw_done), 32'd0);
    run_sweep("abt_after", 16'hFF00, 1'b1);

    // abort+start together in IDLE: nothing starts
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(posedge clk);
    #1 begin start = 1'b0; abort = 1'b0; end
    check("abt_start", 32'(busy), 32'd0);

    // reset mid-sweep
    ckt_mode = 1; expected = 16'hAAAA;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_out", {table_out, 11'd0, match, busy, done, 2'd0}, 32'd0);
    check("mrst_drv", 32'(w_vec), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_sweep("mrst_after", 16'hAAAA, 1'b1);

    // start held high for 200 cycles
    ckt_mode = 2; expected = 16'hFC79;
    n_done = 0; t_first = 0; t_second = 0;
    @(negedge clk) start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1 if (done) begin
        n_done++;
        if (n_done == 1) t_first = k;
        if (n_done == 2) t_second = k;
      end
    end
    start = 1'b0;
    check("hold_count", 32'(n_done), 32'd2);
    check("hold_gap", 32'(t_second - t_first), 32'd82);
    check("hold_tab", 32'(table_out), 32'hFC79);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("hold_abort", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
